branch_pred_btb: RTL and testbench

- Fetch-side branch predictor: 4-way set-associative branch target buffer with a 2-bit saturating counter per entry and tree pseudo-LRU replacement per set.
- Looks up the fetch PC combinationally and supplies predicted-taken, predicted target and way to the fetch/decode pipeline.
- Receives branch resolution from the execute stage (branch, taken, target, PC, way) and updates or allocates entries.
- Is the consumer of the execute stage's resolution interface and the producer of that stage's prediction inputs.

---
 rtl/branch_pred_btb_pkg.sv | 41 ++++
 rtl/branch_pred_btb_plru_tree.sv | 35 +++
 rtl/branch_pred_btb.sv | 166 ++++++++++++++++
 tb/tb_branch_pred_btb.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pred_btb_pkg.sv
// Shared types and helpers for the branch target buffer.
//   btb_entry_t  : one BTB entry (valid, tag, target, 2-bit counter). Tag and
//                  target fields are sized for the widest supported PC (64b);
//                  narrower configurations zero-extend into them.
//   plru_victim  : tree-PLRU victim way from a set's 3 PLRU bits.
//   plru_touch   : PLRU bits after an access, pointing away from that way.
package branch_pred_pkg;

  localparam int N_WAYS     = 4;
  localparam int MAX_ADDR_W = 64;

  localparam logic [1:0] CTR_RESET = 2'b01;  // weakly not-taken
  localparam logic [1:0] CTR_ALLOC = 2'b10;  // weakly taken

  typedef struct packed {
    logic                  valid;
    logic [MAX_ADDR_W-1:0] tag;
    logic [MAX_ADDR_W-1:0] target;
    logic [1:0]            ctr;
  } btb_entry_t;

  // b0 picks the half (0: ways 0/1, 1: ways 2/3); b1/b2 pick within it.
  function automatic logic [1:0] plru_victim(input logic [2:0] plru);
    if (!plru[0]) return plru[1] ? 2'd1 : 2'd0;
    return plru[2] ? 2'd3 : 2'd2;
  endfunction

  function automatic logic [2:0] plru_touch(input logic [2:0] plru,
                                            input logic [1:0] way);
    logic [2:0] p;
    p = plru;
    case (way)
      2'd0:    begin p[0] = 1'b1; p[1] = 1'b1; end
      2'd1:    begin p[0] = 1'b1; p[1] = 1'b0; end
      2'd2:    begin p[0] = 1'b0; p[2] = 1'b1; end
      default: begin p[0] = 1'b0; p[2] = 1'b0; end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/branch_pred_btb_plru_tree.sv
// Per-set tree pseudo-LRU state for the 4-way BTB.
//   i_clk, i_arst            : clock, synchronous active-high reset (bits -> 0)
//   i_rd_idx / o_victim      : combinational victim read for the fetch set
//   i_touch, i_touch_idx,
//   i_touch_way              : mark a way as most recently used at the clock edge
module btb_plru_tree
  import branch_pred_pkg::*;
#(
  parameter int SET_COUNT = 8,
  parameter int INDEX_W   = $clog2(SET_COUNT)
)(
  input  logic               i_clk,
  input  logic               i_arst,
  input  logic [INDEX_W-1:0] i_rd_idx,
  output logic [1:0]         o_victim,
  input  logic               i_touch,
  input  logic [INDEX_W-1:0] i_touch_idx,
  input  logic [1:0]         i_touch_way
);

  logic [2:0] plru_q [SET_COUNT];
  logic [2:0] plru_d;

  assign o_victim = plru_victim(plru_q[i_rd_idx]);
  assign plru_d   = plru_touch(plru_q[i_touch_idx], i_touch_way);

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      for (int s = 0; s < SET_COUNT; s++) plru_q[s] <= 3'b000;
    end else if (i_touch) begin
      plru_q[i_touch_idx] <= plru_d;
    end
  end

endmodule

// File: rtl/branch_pred_btb.sv
// 4-way set-associative branch target buffer with 2-bit counters and
// tree-PLRU replacement.
//   i_clk, i_arst         : clock, synchronous active-high reset
//   i_pc_fetch            : fetch PC, looked up combinationally
//   o_branch_pred_taken   : hit and counter MSB set
//   o_pc_target_pred      : stored target on hit, 0 on miss
//   o_btb_way             : hit way, else allocation candidate for this set
//   i_stall_mem           : blocks updates
//   i_branch_exec, i_branch_taken_exec, i_pc_exec, i_pc_target_exec,
//   i_btb_way_exec        : branch resolution from execute
//   i_branch_mispred      : only consumed by the stats counters
//   o_stat_branches, o_stat_mispred : present only with BRANCH_PRED_STATS_EN
// Lookups see pre-update contents: there is no write-to-read bypass.
// ADDR_WIDTH must not exceed 64.
module branch_pred_btb
  import branch_pred_pkg::*;
#(
  parameter  int ADDR_WIDTH = 64,
  parameter  int SET_COUNT  = 8,
  localparam int INDEX_W    = $clog2(SET_COUNT)
)(
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic [ADDR_WIDTH-1:0] i_pc_fetch,
  output logic                  o_branch_pred_taken,
  output logic [ADDR_WIDTH-1:0] o_pc_target_pred,
  output logic [1:0]            o_btb_way,
  input  logic                  i_stall_mem,
  input  logic                  i_branch_exec,
  input  logic                  i_branch_taken_exec,
  input  logic [ADDR_WIDTH-1:0] i_pc_exec,
  input  logic [ADDR_WIDTH-1:0] i_pc_target_exec,
  input  logic [1:0]            i_btb_way_exec,
`ifdef BRANCH_PRED_STATS_EN
  output logic [31:0]           o_stat_branches,
  output logic [31:0]           o_stat_mispred,
`endif
  input  logic                  i_branch_mispred
);

  localparam int TAG_LSB = INDEX_W + 2;

  btb_entry_t mem_q [SET_COUNT][N_WAYS];

  // ---------------- lookup ----------------
  logic [INDEX_W-1:0]    f_idx;
  logic [MAX_ADDR_W-1:0] f_tag;
  logic                  f_hit, f_inv;
  logic [1:0]            f_hit_way, f_inv_way, f_victim;

  assign f_idx = i_pc_fetch[TAG_LSB-1:2];
  assign f_tag = MAX_ADDR_W'(i_pc_fetch[ADDR_WIDTH-1:TAG_LSB]);

  always_comb begin
    f_hit     = 1'b0;
    f_hit_way = 2'd0;
    f_inv     = 1'b0;
    f_inv_way = 2'd0;
    for (int w = 0; w < N_WAYS; w++) begin
      if (mem_q[f_idx][w].valid && mem_q[f_idx][w].tag == f_tag) begin
        f_hit     = 1'b1;
        f_hit_way = 2'(w);
      end
      // first invalid way wins, so fills go bottom-up before PLRU kicks in
      if (!mem_q[f_idx][w].valid && !f_inv) begin
        f_inv     = 1'b1;
        f_inv_way = 2'(w);
      end
    end
  end

  always_comb begin
    o_branch_pred_taken = 1'b0;
    o_pc_target_pred    = '0;
    o_btb_way           = f_inv ? f_inv_way : f_victim;
    if (f_hit) begin
      o_branch_pred_taken = mem_q[f_idx][f_hit_way].ctr[1];
      o_pc_target_pred    = ADDR_WIDTH'(mem_q[f_idx][f_hit_way].target);
      o_btb_way           = f_hit_way;
    end
  end

  // ---------------- update ----------------
  logic                  upd, x_match, wr_en;
  logic [INDEX_W-1:0]    x_idx;
  logic [MAX_ADDR_W-1:0] x_tag;
  btb_entry_t            x_ent, ent_d;

  assign upd     = i_branch_exec & ~i_stall_mem & ~i_arst;
  assign x_idx   = i_pc_exec[TAG_LSB-1:2];
  assign x_tag   = MAX_ADDR_W'(i_pc_exec[ADDR_WIDTH-1:TAG_LSB]);
  assign x_ent   = mem_q[x_idx][i_btb_way_exec];
  assign x_match = x_ent.valid && (x_ent.tag == x_tag);

  // The carried way is trusted: a tag mismatch there overwrites that way.
  always_comb begin
    ent_d = x_ent;
    wr_en = 1'b0;
    if (upd) begin
      if (x_match) begin
        wr_en = 1'b1;
        if (i_branch_taken_exec) begin
          ent_d.ctr    = (x_ent.ctr == 2'b11) ? 2'b11 : x_ent.ctr + 2'd1;
          ent_d.target = MAX_ADDR_W'(i_pc_target_exec);
        end else begin
          ent_d.ctr    = (x_ent.ctr == 2'b00) ? 2'b00 : x_ent.ctr - 2'd1;
        end
      end else if (i_branch_taken_exec) begin
        wr_en        = 1'b1;
        ent_d.valid  = 1'b1;
        ent_d.tag    = x_tag;
        ent_d.target = MAX_ADDR_W'(i_pc_target_exec);
        ent_d.ctr    = CTR_ALLOC;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      for (int s = 0; s < SET_COUNT; s++)
        for (int w = 0; w < N_WAYS; w++)
          mem_q[s][w] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
    end else if (wr_en) begin
      mem_q[x_idx][i_btb_way_exec] <= ent_d;
    end
  end

  // every entry write is also a PLRU touch
  btb_plru_tree #(.SET_COUNT(SET_COUNT), .INDEX_W(INDEX_W)) u_plru (
    .i_clk       (i_clk),
    .i_arst      (i_arst),
    .i_rd_idx    (f_idx),
    .o_victim    (f_victim),
    .i_touch     (wr_en),
    .i_touch_idx (x_idx),
    .i_touch_way (i_btb_way_exec)
  );

  // ---------------- optional stats ----------------
`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;

  assign stat_br_d = stat_br_q + 32'd1;
  assign stat_mp_d = stat_mp_q + 32'd1;

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else if (upd) begin
      stat_br_q <= stat_br_d;
      if (i_branch_mispred) stat_mp_q <= stat_mp_d;
    end
  end

  assign o_stat_branches = stat_br_q;
  assign o_stat_mispred  = stat_mp_q;
`else
  logic unused_mispred;
  assign unused_mispred = i_branch_mispred;
`endif

  logic [3:0] unused_pc_lsb;
  assign unused_pc_lsb = {i_pc_fetch[1:0], i_pc_exec[1:0]};

endmodule

// File: tb/tb_branch_pred_btb.sv
// Bench for branch_pred_btb (ADDR_WIDTH=64, SET_COUNT=8): directed vector
// table, reset corner sequences, optional stats sequence, then randomized
// traffic against a behavioural model of the BTB.
module tb_branch_pred_btb;

  logic        i_clk = 1'b0;
  logic        i_arst = 1'b1;
  logic [63:0] i_pc_fetch = '0, i_pc_exec = '0, i_pc_target_exec = '0;
  logic        i_stall_mem = 1'b0, i_branch_exec = 1'b0, i_branch_taken_exec = 1'b0;
  logic        i_branch_mispred = 1'b0;
  logic [1:0]  i_btb_way_exec = '0;
  logic        o_branch_pred_taken;
  logic [63:0] o_pc_target_pred;
  logic [1:0]  o_btb_way;
`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] o_stat_branches, o_stat_mispred;
`endif

  branch_pred_btb #(.ADDR_WIDTH(64), .SET_COUNT(8)) dut (
    .i_clk               (i_clk),
    .i_arst              (i_arst),
    .i_pc_fetch          (i_pc_fetch),
    .o_branch_pred_taken (o_branch_pred_taken),
    .o_pc_target_pred    (o_pc_target_pred),
    .o_btb_way           (o_btb_way),
    .i_stall_mem         (i_stall_mem),
    .i_branch_exec       (i_branch_exec),
    .i_branch_taken_exec (i_branch_taken_exec),
    .i_pc_exec           (i_pc_exec),
    .i_pc_target_exec    (i_pc_target_exec),
    .i_btb_way_exec      (i_btb_way_exec),
`ifdef BRANCH_PRED_STATS_EN
    .o_stat_branches     (o_stat_branches),
    .o_stat_mispred      (o_stat_mispred),
`endif
    .i_branch_mispred    (i_branch_mispred)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic etk, input logic [63:0] etg,
                         input logic [1:0] ew);
    chk({nm, "_taken"},  64'(o_branch_pred_taken), 64'(etk));
    chk({nm, "_target"}, o_pc_target_pred, etg);
    chk({nm, "_way"},    64'(o_btb_way), 64'(ew));
  endtask

  task automatic drive(input logic [63:0] pf, input logic br, input logic tk,
                       input logic st, input logic mp, input logic [63:0] px,
                       input logic [63:0] tx, input logic [1:0] wx);
    i_pc_fetch = pf; i_branch_exec = br; i_branch_taken_exec = tk;
    i_stall_mem = st; i_branch_mispred = mp; i_pc_exec = px;
    i_pc_target_exec = tx; i_btb_way_exec = wx;
  endtask

  // ---------------- behavioural model ----------------
  logic        mv [8][4];
  logic [63:0] mt [8][4];
  logic [63:0] mg [8][4];
  int          mc [8][4];
  logic [2:0]  mp [8];
  int          m_br, m_mp;

  function automatic void mreset();
    for (int s = 0; s < 8; s++) begin
      mp[s] = 3'b000;
      for (int w = 0; w < 4; w++) begin
        mv[s][w] = 1'b0; mt[s][w] = '0; mg[s][w] = '0; mc[s][w] = 1;
      end
    end
    m_br = 0; m_mp = 0;
  endfunction

  function automatic void mtouch(input int s, input int w);
    int half;
    half = w / 2;
    mp[s][0] = (half == 0);
    if (half == 0) mp[s][1] = (w == 0);
    else           mp[s][2] = (w == 2);
  endfunction

  function automatic void mlook(input logic [63:0] pc, output logic tk,
                                output logic [63:0] tg, output logic [1:0] wy);
    int s, inv;
    logic [63:0] t;
    s = int'((pc >> 2) & 64'd7);
    t = pc >> 5;
    tk = 1'b0; tg = '0; inv = -1;
    for (int w = 3; w >= 0; w--) if (!mv[s][w]) inv = w;
    if (inv >= 0) wy = 2'(inv);
    else if (!mp[s][0]) wy = mp[s][1] ? 2'd1 : 2'd0;
    else wy = mp[s][2] ? 2'd3 : 2'd2;
    for (int w = 0; w < 4; w++)
      if (mv[s][w] && mt[s][w] == t) begin
        tk = (mc[s][w] >= 2); tg = mg[s][w]; wy = 2'(w);
      end
  endfunction

  function automatic void mupd(input logic [63:0] px, input logic tk,
                               input logic [63:0] tx, input logic [1:0] wx);
    int s, w;
    logic [63:0] t;
    s = int'((px >> 2) & 64'd7);
    t = px >> 5;
    w = int'(wx);
    if (mv[s][w] && mt[s][w] == t) begin
      if (tk) begin
        if (mc[s][w] < 3) mc[s][w] = mc[s][w] + 1;
        mg[s][w] = tx;
      end else if (mc[s][w] > 0) mc[s][w] = mc[s][w] - 1;
      mtouch(s, w);
    end else if (tk) begin
      mv[s][w] = 1'b1; mt[s][w] = t; mg[s][w] = tx; mc[s][w] = 2;
      mtouch(s, w);
    end
  endfunction

  function automatic logic [63:0] rpc();
    logic [63:0] t;
    t = 64'($urandom_range(0, 5));
    if (t == 64'd5) t = 64'h0123_4567_89ab_cde;
    return (t << 5) | (64'($urandom_range(0, 7)) << 2) | 64'($urandom_range(0, 3));
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [63:0] pf;
    logic        br, tk, st;
    logic [63:0] px, tx;
    logic [1:0]  wx;
    logic        etk;
    logic [63:0] etg;
    logic [1:0]  ew;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [63:0] pf, input logic br, input logic tk,
                              input logic st, input logic [63:0] px, input logic [63:0] tx,
                              input logic [1:0] wx, input logic etk,
                              input logic [63:0] etg, input logic [1:0] ew);
    vec_t v;
    v.pf = pf; v.br = br; v.tk = tk; v.st = st; v.px = px; v.tx = tx; v.wx = wx;
    v.etk = etk; v.etg = etg; v.ew = ew;
    tbl.push_back(v);
  endfunction

  initial begin
    logic        etk, tk, br, st, mpb;
    logic [63:0] etg, pf, px, tx;
    logic [1:0]  ew, wx;

    //   fetch   br tk st exec   target  way   exp: tk target  way
    add(64'h100, 0, 0, 0, 64'h0,   64'h0,   2'd0, 0, 64'h0,   2'd0); // reset state
    add(64'h100, 1, 1, 0, 64'h100, 64'h200, 2'd0, 0, 64'h0,   2'd0); // alloc, same-cycle old
    add(64'h100, 1, 0, 0, 64'h100, 64'h0,   2'd0, 1, 64'h200, 2'd0); // ctr 10 -> 01
    add(64'h100, 1, 0, 0, 64'h100, 64'h0,   2'd0, 0, 64'h200, 2'd0); // 01 -> 00
    add(64'h100, 1, 0, 0, 64'h100, 64'h0,   2'd0, 0, 64'h200, 2'd0); // stays 00
    add(64'h100, 1, 1, 0, 64'h100, 64'h200, 2'd0, 0, 64'h200, 2'd0); // 00 -> 01
    add(64'h100, 1, 1, 0, 64'h100, 64'h240, 2'd0, 0, 64'h200, 2'd0); // 01 -> 10, new tgt
    add(64'h100, 0, 0, 0, 64'h0,   64'h0,   2'd0, 1, 64'h240, 2'd0);
    add(64'h120, 1, 1, 0, 64'h120, 64'h300, 2'd1, 0, 64'h0,   2'd1);
    add(64'h140, 1, 1, 0, 64'h140, 64'h400, 2'd2, 0, 64'h0,   2'd2);
    add(64'h160, 1, 1, 0, 64'h160, 64'h500, 2'd3, 0, 64'h0,   2'd3);
    add(64'h180, 0, 0, 0, 64'h0,   64'h0,   2'd0, 0, 64'h0,   2'd0); // full set, plru 000
    add(64'h120, 0, 0, 0, 64'h0,   64'h0,   2'd0, 1, 64'h300, 2'd1);
    add(64'h180, 1, 0, 0, 64'h180, 64'h0,   2'd0, 0, 64'h0,   2'd0); // nt miss: no change
    add(64'h100, 0, 0, 0, 64'h0,   64'h0,   2'd0, 1, 64'h240, 2'd0);
    add(64'h180, 1, 1, 0, 64'h100, 64'h240, 2'd0, 0, 64'h0,   2'd0); // hit, touch w0
    add(64'h180, 0, 0, 0, 64'h0,   64'h0,   2'd0, 0, 64'h0,   2'd2); // victim now w2
    add(64'h180, 1, 1, 1, 64'h180, 64'h600, 2'd2, 0, 64'h0,   2'd2); // stalled x3
    add(64'h180, 1, 1, 1, 64'h180, 64'h600, 2'd2, 0, 64'h0,   2'd2);
    add(64'h180, 1, 1, 1, 64'h180, 64'h600, 2'd2, 0, 64'h0,   2'd2);
    add(64'h140, 0, 0, 0, 64'h0,   64'h0,   2'd0, 1, 64'h400, 2'd2);
    add(64'h180, 0, 0, 0, 64'h0,   64'h0,   2'd0, 0, 64'h0,   2'd2);
    add(64'h104, 0, 0, 0, 64'h0,   64'h0,   2'd0, 0, 64'h0,   2'd0); // other set
    add(64'h103, 0, 0, 0, 64'h0,   64'h0,   2'd0, 1, 64'h240, 2'd0); // pc[1:0] ignored

    drive(64'h100, 0, 0, 0, 0, 0, 0, 0);
    i_arst = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    chk_out("in_reset", 1'b0, 64'h0, 2'd0);
    @(posedge i_clk); #1;
    i_arst = 1'b0;

    foreach (tbl[k]) begin
      drive(tbl[k].pf, tbl[k].br, tbl[k].tk, tbl[k].st, 1'b0, tbl[k].px, tbl[k].tx, tbl[k].wx);
      @(negedge i_clk);
      chk_out($sformatf("row%0d", k), tbl[k].etk, tbl[k].etg, tbl[k].ew);
      @(posedge i_clk); #1;
    end

    // reset asserted together with a taken update: reset wins, and clears state
    i_arst = 1'b1;
    drive(64'h100, 1, 1, 0, 0, 64'h1000, 64'habc, 2'd1);
    @(posedge i_clk); #1;
    i_arst = 1'b0;
    drive(64'h1000, 0, 0, 0, 0, 0, 0, 0);
    @(negedge i_clk);
    chk_out("rst_wins", 1'b0, 64'h0, 2'd0);
    i_pc_fetch = 64'h100;
    #1;
    chk_out("rst_clears", 1'b0, 64'h0, 2'd0);
    @(posedge i_clk); #1;

`ifdef BRANCH_PRED_STATS_EN
    chk("stat_br_reset", 64'(o_stat_branches), 64'd0);
    chk("stat_mp_reset", 64'(o_stat_mispred), 64'd0);
    for (int n = 0; n < 7; n++) begin
      // 5 real updates (2 mispredicted), one stalled and one idle cycle with mispred
      drive(64'h0, (n != 6), 1'b0, (n == 5), (n < 2) || (n >= 5), 64'h700, 64'h0, 2'd0);
      @(posedge i_clk); #1;
    end
    drive(64'h0, 0, 0, 0, 0, 0, 0, 0);
    chk("stat_br_5", 64'(o_stat_branches), 64'd5);
    chk("stat_mp_2", 64'(o_stat_mispred), 64'd2);
`endif

    // randomized traffic vs model
    i_arst = 1'b1;
    @(posedge i_clk); #1;
    i_arst = 1'b0;
    mreset();
    for (int n = 0; n < 800; n++) begin
      pf  = rpc();
      px  = rpc();
      br  = ($urandom_range(0, 3) != 0);
      tk  = 1'($urandom_range(0, 1));
      st  = ($urandom_range(0, 7) == 0);
      mpb = 1'($urandom_range(0, 1));
      tx  = {$urandom, $urandom};
      mlook(px, etk, etg, wx);
      // a stray way only when the PC is absent, so no tag is ever duplicated
      if (etg == 64'h0 && !(etk) && $urandom_range(0, 3) == 0) begin
        logic [63:0] dummy_t; logic dummy_k; logic [1:0] dummy_w;
        mlook(px, dummy_k, dummy_t, dummy_w);
        if (dummy_t == 64'h0) wx = 2'($urandom_range(0, 3));
      end
      drive(pf, br, tk, st, mpb, px, tx, wx);
      @(negedge i_clk);
      mlook(pf, etk, etg, ew);
      chk_out($sformatf("rnd%0d", n), etk, etg, ew);
      if (br && !st) begin
        mupd(px, tk, tx, wx);
        m_br++;
        if (mpb) m_mp++;
      end
      @(posedge i_clk); #1;
    end
    drive(64'h0, 0, 0, 0, 0, 0, 0, 0);
`ifdef BRANCH_PRED_STATS_EN
    chk("stat_br_rnd", 64'(o_stat_branches), 64'(m_br));
    chk("stat_mp_rnd", 64'(o_stat_mispred), 64'(m_mp));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
